// File: rtl/fifo_pkg.sv
// Shared constants and elaboration helpers for the synchronous FIFO family.
// Read-mode selectors and a power-of-two check used at elaboration time.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit thresh_ok(input int thresh, input int depth);
        return (thresh >= 0) && (thresh <= depth);
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Storage array for the FIFO: one synchronous write port, one asynchronous read port.
// No reset; contents are only meaningful where the pointer logic says so.
module fifo_dpram #(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [DATAWIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]    raddr,
    output logic [DATAWIDTH-1:0] rdata
);

    logic [DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_v2.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags, synchronous flush and standard or FWFT read mode.
module fifo_sync_v2
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int DEPTH     = 8,
    parameter int PTR_LEN   = $clog2(DEPTH),
    parameter int AF_THRESH = DEPTH - 1,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = FIFO_MODE_STD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [DATAWIDTH-1:0] data_in,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [DATAWIDTH-1:0] data_out,
    output logic                 rd_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_LEN:0]     count,
    output logic                 overflow,
    output logic                 underflow
);

    // Handshake: a write is taken on any edge where wr_en && !full && !clr, a read
    // on any edge where rd_en && !empty && !clr; requests against full/empty are
    // dropped (not stalled) and recorded in the sticky overflow/underflow flags.

    if (!is_pow2(DEPTH)) begin : g_chk_depth
        $error("fifo_sync_v2: DEPTH must be a power of two >= 2");
    end
    if (!thresh_ok(AF_THRESH, DEPTH)) begin : g_chk_af
        $error("fifo_sync_v2: AF_THRESH must lie in 0..DEPTH");
    end
    if (!thresh_ok(AE_THRESH, DEPTH)) begin : g_chk_ae
        $error("fifo_sync_v2: AE_THRESH must lie in 0..DEPTH");
    end
    if (PTR_LEN != $clog2(DEPTH)) begin : g_chk_ptr
        $error("fifo_sync_v2: PTR_LEN is derived from DEPTH and must not be overridden");
    end

    localparam logic [PTR_LEN:0] PTR_ONE = 1;
    localparam logic [PTR_LEN:0] AF_LVL  = (PTR_LEN + 1)'(AF_THRESH);
    localparam logic [PTR_LEN:0] AE_LVL  = (PTR_LEN + 1)'(AE_THRESH);

    logic [PTR_LEN:0]     wr_ptr;
    logic [PTR_LEN:0]     rd_ptr;
    logic                 wr_accept;
    logic                 rd_accept;
    logic                 overflow_q;
    logic                 underflow_q;
    logic [DATAWIDTH-1:0] mem_rdata;

    // Flags and count derive only from registered pointers.
    assign full  = (wr_ptr[PTR_LEN] != rd_ptr[PTR_LEN]) &&
                   (wr_ptr[PTR_LEN-1:0] == rd_ptr[PTR_LEN-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_accept = wr_en && !full  && !clr;
    assign rd_accept = rd_en && !empty && !clr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_dpram #(
        .DATAWIDTH (DATAWIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (PTR_LEN)
    ) u_mem (
        .clk   (clk),
        .we    (wr_accept),
        .waddr (wr_ptr[PTR_LEN-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[PTR_LEN-1:0]),
        .rdata (mem_rdata)
    );

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is presented continuously; rd_en only acknowledges it.
        assign data_out = mem_rdata;
        assign rd_valid = !empty;
    end else begin : g_std
        logic [DATAWIDTH-1:0] data_q;
        logic                 valid_q;

        // data_out holds the last word read; only flush or reset clears it.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else if (clr) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                valid_q <= rd_accept;
                if (rd_accept) begin
                    data_q <= mem_rdata;
                end
            end
        end

        assign data_out = data_q;
        assign rd_valid = valid_q;
    end

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Directed bench for fifo_sync_v2: one standard-mode and one FWFT instance, DEPTH=8.
module tb_fifo_sync_v2;

    logic clk;
    logic rst;

    logic       s_clr, s_wr_en, s_rd_en;
    logic [7:0] s_din, s_dout;
    logic       s_rd_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [3:0] s_count;

    logic       f_clr, f_wr_en, f_rd_en;
    logic [7:0] f_din, f_dout;
    logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] f_count;

    int n_tests;
    int n_fail;
    logic [7:0] exp_q[$];
    logic [7:0] exp_d;

    fifo_sync_v2 #(.DATAWIDTH(8), .DEPTH(8), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clr(s_clr), .data_in(s_din), .wr_en(s_wr_en),
        .rd_en(s_rd_en), .data_out(s_dout), .rd_valid(s_rd_valid), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_sync_v2 #(.DATAWIDTH(8), .DEPTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(f_clr), .data_in(f_din), .wr_en(f_wr_en),
        .rd_en(f_rd_en), .data_out(f_dout), .rd_valid(f_rd_valid), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic s_push(input logic [7:0] d);
        s_wr_en = 1'b1;
        s_din   = d;
        exp_q.push_back(d);
        tick();
        s_wr_en = 1'b0;
    endtask

    task automatic s_pop_check(input string tag);
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        exp_d = exp_q.pop_front();
        check({tag, "_data"}, 32'(s_dout), 32'(exp_d));
        check({tag, "_valid"}, 32'(s_rd_valid), 32'd1);
    endtask

    task automatic f_push(input logic [7:0] d);
        f_wr_en = 1'b1;
        f_din   = d;
        tick();
        f_wr_en = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        s_clr = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_din = 8'h00;
        f_clr = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_din = 8'h00;

        #12;
        check("rst_count", 32'(s_count), 32'd0);
        check("rst_empty", 32'(s_empty), 32'd1);
        check("rst_full", 32'(s_full), 32'd0);
        check("rst_ae", 32'(s_ae), 32'd1);
        check("rst_af", 32'(s_af), 32'd0);
        check("rst_dout", 32'(s_dout), 32'd0);
        check("rst_valid", 32'(s_rd_valid), 32'd0);
        check("rst_ovf", 32'(s_ovf), 32'd0);
        check("rst_unf", 32'(s_unf), 32'd0);
        check("rst_f_valid", 32'(f_rd_valid), 32'd0);
        rst = 1'b1;
        tick();

        // FWFT: written word appears right after its edge, rd_en pops it
        f_push(8'hA5);
        check("fwft_dout", 32'(f_dout), 32'hA5);
        check("fwft_valid", 32'(f_rd_valid), 32'd1);
        check("fwft_count", 32'(f_count), 32'd1);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check("fwft_pop_empty", 32'(f_empty), 32'd1);
        check("fwft_pop_valid", 32'(f_rd_valid), 32'd0);
        f_push(8'hB1);
        f_push(8'hB2);
        check("fwft_head1", 32'(f_dout), 32'hB1);
        f_rd_en = 1'b1;
        tick();
        f_rd_en = 1'b0;
        check("fwft_head2", 32'(f_dout), 32'hB2);
        check("fwft_count2", 32'(f_count), 32'd1);
        f_rd_en = 1'b1;
        tick();
        check("fwft_empty2", 32'(f_empty), 32'd1);
        tick();
        f_rd_en = 1'b0;
        check("fwft_unf", 32'(f_unf), 32'd1);

        // Standard mode: fill, overflow, drain
        for (int i = 0; i < 8; i++) begin
            s_push(8'(8'h11 + i));
            check("fill_count", 32'(s_count), 32'(i + 1));
            check("fill_af", 32'(s_af), (i + 1 >= 7) ? 32'd1 : 32'd0);
            check("fill_ae", 32'(s_ae), (i + 1 <= 1) ? 32'd1 : 32'd0);
            check("fill_full", 32'(s_full), (i + 1 == 8) ? 32'd1 : 32'd0);
        end
        s_wr_en = 1'b1;
        s_din   = 8'h99;
        tick();
        s_wr_en = 1'b0;
        check("ovf_set", 32'(s_ovf), 32'd1);
        check("ovf_count", 32'(s_count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            s_pop_check("drain");
        end
        tick();
        check("drain_valid_low", 32'(s_rd_valid), 32'd0);
        check("drain_hold", 32'(s_dout), 32'h18);
        check("drain_empty", 32'(s_empty), 32'd1);

        // Underflow, then flush
        s_rd_en = 1'b1;
        tick();
        s_rd_en = 1'b0;
        check("unf_set", 32'(s_unf), 32'd1);
        check("unf_valid", 32'(s_rd_valid), 32'd0);
        check("unf_dout", 32'(s_dout), 32'h18);
        check("ovf_sticky", 32'(s_ovf), 32'd1);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        check("clr_unf", 32'(s_unf), 32'd0);
        check("clr_ovf", 32'(s_ovf), 32'd0);
        check("clr_dout", 32'(s_dout), 32'd0);
        check("clr_count", 32'(s_count), 32'd0);

        // Steady state at count 4 with simultaneous read/write
        for (int i = 0; i < 4; i++) s_push(8'(8'h20 + i));
        check("ss_pre_count", 32'(s_count), 32'd4);
        for (int i = 0; i < 10; i++) begin
            s_wr_en = 1'b1;
            s_rd_en = 1'b1;
            s_din   = 8'(8'h24 + i);
            exp_q.push_back(s_din);
            tick();
            exp_d = exp_q.pop_front();
            check("ss_data", 32'(s_dout), 32'(exp_d));
            check("ss_count", 32'(s_count), 32'd4);
        end
        s_wr_en = 1'b0;
        s_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) s_pop_check("ss_drain");

        // Full with simultaneous read/write: read taken, write dropped
        for (int i = 0; i < 8; i++) s_push(8'(8'h30 + i));
        check("full2", 32'(s_full), 32'd1);
        s_wr_en = 1'b1;
        s_rd_en = 1'b1;
        s_din   = 8'hEE;
        tick();
        s_wr_en = 1'b0;
        s_rd_en = 1'b0;
        exp_d = exp_q.pop_front();
        check("fullrw_data", 32'(s_dout), 32'(exp_d));
        check("fullrw_count", 32'(s_count), 32'd7);
        check("fullrw_ovf", 32'(s_ovf), 32'd1);
        check("fullrw_full", 32'(s_full), 32'd0);
        s_pop_check("pre_rst");
        s_pop_check("pre_rst");
        check("pre_rst_count", 32'(s_count), 32'd5);

        // Asynchronous reset between edges
        #3;
        rst = 1'b0;
        #1;
        check("arst_count", 32'(s_count), 32'd0);
        check("arst_empty", 32'(s_empty), 32'd1);
        check("arst_dout", 32'(s_dout), 32'd0);
        check("arst_ovf", 32'(s_ovf), 32'd0);
        #2;
        rst = 1'b1;
        exp_q.delete();
        s_push(8'h5A);
        s_pop_check("post_rst");
        check("post_rst_count", 32'(s_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
